gate_preact_mac: RTL and testbench



---
 rtl/gate_preact_pkg.sv | 21 ++
 rtl/gate_preact_mac_fxp_mul_shift.sv | 21 ++
 rtl/gate_preact_mac.sv | 49 ++++
 tb/tb_gate_preact_mac.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gate_preact_pkg.sv
// gate_preact_pkg: Q16 constants, FSM state type and accumulator-to-output saturation for gate_preact_mac
package gate_preact_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int ACC_W = 48;
  localparam int Q_ONE = 1 << FRAC_W;
  localparam int Q_HALF = Q_ONE >> 1;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  typedef struct packed {
    logic sat;
    logic [DATA_W-1:0] data;
  } sat_t;
  function automatic sat_t sat_narrow(input logic [ACC_W-1:0] acc);
    logic [ACC_W-DATA_W:0] top;
    sat_t r;
    top = acc[ACC_W-1:DATA_W-1];
    r.sat = !(top == '0 || top == '1);
    r.data = !r.sat ? acc[DATA_W-1:0] : acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return r;
  endfunction
endpackage

// File: rtl/gate_preact_mac_fxp_mul_shift.sv
// fxp_mul_shift: combinational signed Q multiply, >>> FRAC_WIDTH (truncate, or round half up with GATE_PREACT_ROUND_EN); ports a, b in, p out
module fxp_mul_shift
  import gate_preact_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int OUT_WIDTH = ACC_W
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [OUT_WIDTH-1:0]  p
);
`ifdef GATE_PREACT_ROUND_EN
  localparam int RND = Q_HALF >> (FRAC_W - FRAC_WIDTH);
`else
  localparam int RND = 0 * Q_HALF;
`endif
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = a * b + (2*DATA_WIDTH)'(RND);
  assign p = OUT_WIDTH'(prod >>> FRAC_WIDTH);
endmodule

// File: rtl/gate_preact_mac.sv
// gate_preact_mac: streaming Q16 dot product + bias with saturated output (clk, rst, in_valid/in_ready/in_weight/in_x/in_bias/in_last, out_valid/out_ready/out_data/out_sat; GATE_PREACT_ROUND_EN rounds products)
module gate_preact_mac
  import gate_preact_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int ACC_WIDTH = ACC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_weight,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_bias,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_sat
);
  state_t state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, p;
  logic xfer;
  fxp_mul_shift #(.DATA_WIDTH(DATA_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .OUT_WIDTH(ACC_WIDTH)) u_mul (
    .a(in_weight),
    .b(in_x),
    .p(p)
  );
  always_comb begin
    in_ready = !rst && state != HOLD;
    out_valid = state == HOLD;
    xfer = in_valid && in_ready;
    acc_next = (state == IDLE ? ACC_WIDTH'(in_bias) : acc) + p;
    state_n = state == HOLD ? (out_ready ? IDLE : HOLD) : xfer ? (in_last ? HOLD : ACCUM) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer) acc <= acc_next;
      if (xfer && in_last) {out_sat, out_data} <= sat_narrow(acc_next);
    end
  end
endmodule

// File: tb/tb_gate_preact_mac.sv
// tb_gate_preact_mac: directed self-checking bench for gate_preact_mac
module tb_gate_preact_mac;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic in_ready, out_valid, out_sat;
  logic [31:0] in_weight = 0, in_x = 0, in_bias = 0, out_data;
  int n_checks = 0, n_fail = 0;

  gate_preact_mac dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_x(in_x), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] w, x, b, input logic last, input int gap);
    in_valid = 1; in_weight = w; in_x = x; in_bias = b; in_last = last;
    step();
    in_valid = 0;
    repeat (gap) step();
  endtask

  task automatic test_reset();
    #2;
    n_checks += 4;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", out_data); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset out_sat: got %b want 0", out_sat); end
    step();
    step();
    rst = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    beat(32'd65536, 32'd131072, 32'd32768, 1, 0);
    n_checks += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single out_valid: got %b want 1", out_valid); end
    if (out_data !== 32'd163840) begin n_fail++; $display("FAIL single data: got %0d want 163840", $signed(out_data)); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL single sat: got %b want 0", out_sat); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single hold in_ready: got %b want 0", in_ready); end
    step();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single drain out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single drain in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_multi(input int gap);
    beat(32'd65536, 32'd16384, 32'd0, 0, gap);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL multi gap%0d early out_valid: got %b want 0", gap, out_valid); end
    beat(32'd65536, -32'sd8192, 32'd999, 0, gap);
    beat(32'd65536, 32'd4096, 32'd999, 0, gap);
    beat(32'd65536, 32'd4096, 32'd999, 1, 0);
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL multi gap%0d out_valid: got %b want 1", gap, out_valid); end
    if (out_data !== 32'd16384) begin n_fail++; $display("FAIL multi gap%0d data: got %0d want 16384", gap, $signed(out_data)); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL multi gap%0d sat: got %b want 0", gap, out_sat); end
    step();
  endtask

  task automatic test_saturation();
    beat(32'h0010_0000, 32'h0010_0000, 32'h7FFF_0000, 1, 0);
    n_checks += 2;
    if (out_data !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat pos data: got %h want 7fffffff", out_data); end
    if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat pos flag: got %b want 1", out_sat); end
    step();
    beat(32'h0010_0000, 32'hFFF0_0000, 32'h8001_0000, 1, 0);
    n_checks += 2;
    if (out_data !== 32'h8000_0000) begin n_fail++; $display("FAIL sat neg data: got %h want 80000000", out_data); end
    if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat neg flag: got %b want 1", out_sat); end
    step();
    beat(32'd65536, 32'h0000_FFFF, 32'h7FFF_0000, 1, 0);
    n_checks += 2;
    if (out_data !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL edge max data: got %h want 7fffffff", out_data); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL edge max flag: got %b want 0", out_sat); end
    step();
    beat(32'd0, 32'd12345, 32'h8000_0000, 1, 0);
    n_checks += 2;
    if (out_data !== 32'h8000_0000) begin n_fail++; $display("FAIL edge min data: got %h want 80000000", out_data); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL edge min flag: got %b want 0", out_sat); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    beat(32'd0, 32'd0, 32'd7, 1, 0);
    in_valid = 1; in_weight = 0; in_x = 0; in_bias = 32'd100; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d out_valid: got %b want 1", i, out_valid); end
      if (out_data !== 32'd7) begin n_fail++; $display("FAIL bp%0d data: got %0d want 7", i, out_data); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d in_ready: got %b want 0", i, in_ready); end
      step();
    end
    in_valid = 0;
    out_ready = 1;
    step();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp release out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    beat(32'd0, 32'd0, 32'd9, 1, 0);
    n_checks++;
    if (out_data !== 32'd9) begin n_fail++; $display("FAIL bp next data: got %0d want 9", out_data); end
    step();
  endtask

  task automatic test_rounding();
    logic [31:0] exp_pos, exp_neg;
`ifdef GATE_PREACT_ROUND_EN
    exp_pos = 32'd1;
    exp_neg = 32'd0;
`else
    exp_pos = 32'd0;
    exp_neg = 32'hFFFF_FFFF;
`endif
    beat(32'd1, 32'd32768, 32'd0, 1, 0);
    n_checks++;
    if (out_data !== exp_pos) begin n_fail++; $display("FAIL round pos: got %0d want %0d", $signed(out_data), $signed(exp_pos)); end
    step();
    beat(32'hFFFF_FFFF, 32'd32768, 32'd0, 1, 0);
    n_checks++;
    if (out_data !== exp_neg) begin n_fail++; $display("FAIL round neg: got %0d want %0d", $signed(out_data), $signed(exp_neg)); end
    step();
  endtask

  task automatic test_reset_mid();
    beat(32'd65536, 32'd65536, 32'd1000, 0, 0);
    beat(32'd65536, 32'd65536, 32'd0, 0, 0);
    rst = 1;
    #1;
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    step();
    rst = 0;
    step();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL postrst in_ready: got %b want 1", in_ready); end
    beat(32'd0, 32'd77, 32'd5, 1, 0);
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL postrst vec valid: got %b want 1", out_valid); end
    if (out_data !== 32'd5) begin n_fail++; $display("FAIL postrst vec data: got %0d want 5", out_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi(0);
    test_multi(2);
    test_saturation();
    test_backpressure();
    test_rounding();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
